// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings, shadow-stage records and forwarding helpers for the
// 5-stage pipeline hazard controller.
package pipeline_ctrl_pkg;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;
    localparam logic [1:0] WB_X   = 2'd3;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_MEM  = 2'd1;
    localparam logic [1:0] FWD_WB   = 2'd2;

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_STALL  = 2'd1,
        MODE_FLUSH  = 2'd2,
        MODE_FREEZE = 2'd3
    } mode_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rf_wen;
        logic [1:0] wb_sel;
    } stage_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_use;
        logic       rs2_use;
    } ex_src_t;

    localparam stage_t STAGE_EMPTY = '{valid: 1'b0, rd: 5'd0, rf_wen: 1'b0, wb_sel: 2'd0};
    localparam ex_src_t SRC_EMPTY  = '{rs1: 5'd0, rs2: 5'd0, rs1_use: 1'b0, rs2_use: 1'b0};

    // A stage can supply addr; a load's data is not available yet in MEM.
    function automatic logic stage_hit(input stage_t s, input logic [4:0] addr,
                                       input logic allow_load);
        return s.valid && s.rf_wen && (s.rd == addr) &&
               (allow_load || (s.wb_sel != WB_MEM));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic use_i, input logic [4:0] addr,
                                           input stage_t mem_s, input stage_t wb_s);
        logic [1:0] sel;
        sel = FWD_NONE;
        if (!use_i || (addr == 5'd0)) begin
            sel = FWD_NONE;
        end else if (stage_hit(mem_s, addr, 1'b0)) begin
            sel = FWD_MEM;
        end else if (stage_hit(wb_s, addr, 1'b1)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decoder/hazard inputs and pipeline control outputs of the hazard controller.
interface pipeline_ctrl_if #(parameter int CNT_W = 16);

    logic             id_valid;
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             id_rs1_use;
    logic             id_rs2_use;
    logic [4:0]       id_rd_addr;
    logic             id_rf_wen;
    logic [1:0]       id_wb_sel;
    logic             ex_br_taken;
    logic             mem_busy;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic [1:0]       ex_fwd_rs1;
    logic [1:0]       ex_fwd_rs2;
    logic             ex_valid;
    logic             mem_valid;
    logic             wb_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_use, id_rs2_use,
               id_rd_addr, id_rf_wen, id_wb_sel, ex_br_taken, mem_busy,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
               id_ex_bubble, ex_fwd_rs1, ex_fwd_rs2, ex_valid, mem_valid,
               wb_valid, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_use, id_rs2_use,
               id_rd_addr, id_rf_wen, id_wb_sel, ex_br_taken, mem_busy,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
               id_ex_bubble, ex_fwd_rs1, ex_fwd_rs2, ex_valid, mem_valid,
               wb_valid, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating event counter: counts inc pulses unless held, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             hold,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: increment only while below the saturation value.
    always_comb begin
        count_d = count_q;
        if (hold) begin
            count_d = count_q;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: shadow stage tracking,
// stall/flush/freeze control, EX forwarding selects and event counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pipeline_ctrl_if.slave bus
);

    stage_t  ex_q, ex_d;
    stage_t  mem_q, mem_d;
    stage_t  wb_q, wb_d;
    ex_src_t ex_src_q, ex_src_d;

    mode_e mode_s;
    logic  load_use_s;
    logic  bubble_s;

    // Load-use hazard: a load in EX feeds a source the ID instruction reads.
    always_comb begin
        load_use_s = 1'b0;
        if (ex_q.valid && ex_q.rf_wen && (ex_q.wb_sel == WB_MEM) &&
            (ex_q.rd != 5'd0) && bus.id_valid) begin
            load_use_s = (bus.id_rs1_use && (bus.id_rs1_addr == ex_q.rd)) ||
                         (bus.id_rs2_use && (bus.id_rs2_addr == ex_q.rd));
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Mode select and pipeline-register controls; freeze outranks a pending branch.
    always_comb begin
        mode_s           = MODE_RUN;
        bus.pc_en        = 1'b1;
        bus.if_id_en     = 1'b1;
        bus.id_ex_en     = 1'b1;
        bus.ex_mem_en    = 1'b1;
        bus.mem_wb_en    = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_bubble = 1'b0;

        if (bus.mem_busy) begin
            mode_s = MODE_FREEZE;
        end else if (bus.ex_br_taken) begin
            mode_s = MODE_FLUSH;
        end else if (load_use_s) begin
            mode_s = MODE_STALL;
        end else begin
            mode_s = MODE_RUN;
        end

        case (mode_s)
            MODE_FREEZE: begin
                bus.pc_en     = 1'b0;
                bus.if_id_en  = 1'b0;
                bus.id_ex_en  = 1'b0;
                bus.ex_mem_en = 1'b0;
                bus.mem_wb_en = 1'b0;
            end
            MODE_FLUSH: begin
                bus.if_id_flush  = 1'b1;
                bus.id_ex_bubble = 1'b1;
            end
            MODE_STALL: begin
                bus.pc_en        = 1'b0;
                bus.if_id_en     = 1'b0;
                bus.id_ex_bubble = 1'b1;
            end
            MODE_RUN: begin
                bus.pc_en = 1'b1;
            end
            default: begin
                bus.pc_en = 1'b1;
            end
        endcase
    end

    assign bubble_s = (mode_s == MODE_FLUSH) || (mode_s == MODE_STALL);

    // Shadow advance: everything holds while frozen, bubbles enter EX as invalid.
    always_comb begin
        ex_d     = ex_q;
        ex_src_d = ex_src_q;
        mem_d    = mem_q;
        wb_d     = wb_q;
        if (mode_s != MODE_FREEZE) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (bubble_s) begin
                ex_d     = STAGE_EMPTY;
                ex_src_d = SRC_EMPTY;
            end else begin
                ex_d.valid        = bus.id_valid;
                ex_d.rd           = bus.id_rd_addr;
                ex_d.rf_wen       = bus.id_rf_wen;
                ex_d.wb_sel       = bus.id_wb_sel;
                ex_src_d.rs1      = bus.id_rs1_addr;
                ex_src_d.rs2      = bus.id_rs2_addr;
                ex_src_d.rs1_use  = bus.id_rs1_use;
                ex_src_d.rs2_use  = bus.id_rs2_use;
            end
        end else begin
            wb_d = wb_q;
        end
    end

    // Shadow stage registers; reset empties the whole pipeline view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= STAGE_EMPTY;
            ex_src_q <= SRC_EMPTY;
            mem_q    <= STAGE_EMPTY;
            wb_q     <= STAGE_EMPTY;
        end else begin
            ex_q     <= ex_d;
            ex_src_q <= ex_src_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
        end
    end

    // Operand forwarding for the instruction currently in EX; MEM is the younger producer.
    always_comb begin
        bus.ex_fwd_rs1 = fwd_sel(ex_src_q.rs1_use, ex_src_q.rs1, mem_q, wb_q);
        bus.ex_fwd_rs2 = fwd_sel(ex_src_q.rs2_use, ex_src_q.rs2, mem_q, wb_q);
    end

    assign bus.ex_valid  = ex_q.valid;
    assign bus.mem_valid = mem_q.valid;
    assign bus.wb_valid  = wb_q.valid;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mode_s == MODE_STALL),
        .hold  (bus.mem_busy),
        .count (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mode_s == MODE_FLUSH),
        .hold  (bus.mem_busy),
        .count (bus.flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, forwarding, freeze, saturation, reset.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int CW = 4;
    localparam logic [6:0] CTL_RUN    = 7'b1111100;
    localparam logic [6:0] CTL_STALL  = 7'b0011101;
    localparam logic [6:0] CTL_FLUSH  = 7'b1111111;
    localparam logic [6:0] CTL_FREEZE = 7'b0000000;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pipeline_ctrl_if #(.CNT_W(CW)) bus();

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble}
    function automatic logic [6:0] ctl();
        return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                bus.mem_wb_en, bus.if_id_flush, bus.id_ex_bubble};
    endfunction

    function automatic logic [2:0] vld();
        return {bus.ex_valid, bus.mem_valid, bus.wb_valid};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic wen, input logic [1:0] wbs);
        bus.id_valid    = v;
        bus.id_rs1_addr = rs1;
        bus.id_rs1_use  = u1;
        bus.id_rs2_addr = rs2;
        bus.id_rs2_use  = u2;
        bus.id_rd_addr  = rd;
        bus.id_rf_wen   = wen;
        bus.id_wb_sel   = wbs;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, WB_X);
    endtask

    task automatic drain();
        nop();
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ex_br_taken = 1'b0;
        bus.mem_busy    = 1'b0;
        nop();
        #2;
        n_cmp++; if (ctl() !== CTL_RUN) begin n_err++; $display("FAIL rst_ctl: got %b want %b", ctl(), CTL_RUN); end
        n_cmp++; if (vld() !== 3'b000) begin n_err++; $display("FAIL rst_valid: got %b want 000", vld()); end
        n_cmp++; if ({bus.ex_fwd_rs1, bus.ex_fwd_rs2} !== 4'b0000) begin n_err++; $display("FAIL rst_fwd: got %b want 0000", {bus.ex_fwd_rs1, bus.ex_fwd_rs2}); end
        n_cmp++; if ({bus.stall_cnt, bus.flush_cnt} !== 8'd0) begin n_err++; $display("FAIL rst_cnt: got %h want 00", {bus.stall_cnt, bus.flush_cnt}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, WB_MEM);   // lw x5,0(x1)
        #1;
        n_cmp++; if (ctl() !== CTL_RUN) begin n_err++; $display("FAIL lu_lw_ctl: got %b want %b", ctl(), CTL_RUN); end
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, WB_ALU);   // add x6,x5,x2
        #1;
        n_cmp++; if (ctl() !== CTL_STALL) begin n_err++; $display("FAIL lu_stall_ctl: got %b want %b", ctl(), CTL_STALL); end
        tick();
        n_cmp++; if (bus.stall_cnt !== 4'd1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cnt); end
        n_cmp++; if (vld() !== 3'b010) begin n_err++; $display("FAIL lu_bubble_valid: got %b want 010", vld()); end
        #1;
        n_cmp++; if (ctl() !== CTL_RUN) begin n_err++; $display("FAIL lu_one_cycle: got %b want %b", ctl(), CTL_RUN); end
        tick();
        nop();
        #1;
        n_cmp++; if (bus.ex_fwd_rs1 !== FWD_WB) begin n_err++; $display("FAIL lu_fwd_rs1: got %0d want %0d", bus.ex_fwd_rs1, FWD_WB); end
        n_cmp++; if (bus.ex_fwd_rs2 !== FWD_NONE) begin n_err++; $display("FAIL lu_fwd_rs2: got %0d want %0d", bus.ex_fwd_rs2, FWD_NONE); end
        drain();
    endtask

    task automatic test_forward();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, WB_ALU);   // addi x3,x0,1
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, WB_ALU);   // add x4,x3,x3
        #1;
        n_cmp++; if (ctl() !== CTL_RUN) begin n_err++; $display("FAIL fw_nostall: got %b want %b", ctl(), CTL_RUN); end
        tick();
        nop();
        #1;
        n_cmp++; if ({bus.ex_fwd_rs1, bus.ex_fwd_rs2} !== {FWD_MEM, FWD_MEM}) begin n_err++; $display("FAIL fw_mem: got %b want 0101", {bus.ex_fwd_rs1, bus.ex_fwd_rs2}); end
        drain();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, WB_ALU);
        tick();
        nop();
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, WB_ALU);
        tick();
        nop();
        #1;
        n_cmp++; if ({bus.ex_fwd_rs1, bus.ex_fwd_rs2} !== {FWD_WB, FWD_WB}) begin n_err++; $display("FAIL fw_wb: got %b want 1010", {bus.ex_fwd_rs1, bus.ex_fwd_rs2}); end
        drain();
        // two producers of x3 in flight: MEM is younger and must win
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, WB_ALU);
        tick();
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, WB_ALU);
        tick();
        nop();
        #1;
        n_cmp++; if (bus.ex_fwd_rs1 !== FWD_MEM) begin n_err++; $display("FAIL fw_mem_beats_wb: got %0d want %0d", bus.ex_fwd_rs1, FWD_MEM); end
        drain();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, WB_PC);    // jal x1
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, WB_ALU);   // add x2,x0,x1 (rs2 only)
        tick();
        nop();
        #1;
        n_cmp++; if ({bus.ex_fwd_rs1, bus.ex_fwd_rs2} !== {FWD_NONE, FWD_MEM}) begin n_err++; $display("FAIL fw_jal_rs2: got %b want 0001", {bus.ex_fwd_rs1, bus.ex_fwd_rs2}); end
        drain();
    endtask

    task automatic test_flush();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, WB_MEM);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, WB_ALU);
        bus.ex_br_taken = 1'b1;
        #1;
        n_cmp++; if (ctl() !== CTL_FLUSH) begin n_err++; $display("FAIL fl_ctl: got %b want %b", ctl(), CTL_FLUSH); end
        tick();
        bus.ex_br_taken = 1'b0;
        nop();
        #1;
        n_cmp++; if (bus.flush_cnt !== 4'd1) begin n_err++; $display("FAIL fl_flush_cnt: got %0d want 1", bus.flush_cnt); end
        n_cmp++; if (bus.stall_cnt !== 4'd1) begin n_err++; $display("FAIL fl_stall_cnt: got %0d want 1", bus.stall_cnt); end
        n_cmp++; if (vld() !== 3'b010) begin n_err++; $display("FAIL fl_valid: got %b want 010", vld()); end
        drain();
    endtask

    task automatic test_freeze();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, WB_ALU);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, WB_ALU);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, WB_ALU);
        bus.ex_br_taken = 1'b1;
        bus.mem_busy    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (ctl() !== CTL_FREEZE) begin n_err++; $display("FAIL fz_ctl[%0d]: got %b want %b", i, ctl(), CTL_FREEZE); end
            tick();
            n_cmp++; if (vld() !== 3'b110) begin n_err++; $display("FAIL fz_valid[%0d]: got %b want 110", i, vld()); end
        end
        bus.mem_busy = 1'b0;
        #1;
        n_cmp++; if (ctl() !== CTL_FLUSH) begin n_err++; $display("FAIL fz_flush_ctl: got %b want %b", ctl(), CTL_FLUSH); end
        n_cmp++; if (bus.flush_cnt !== 4'd1) begin n_err++; $display("FAIL fz_cnt_hold: got %0d want 1", bus.flush_cnt); end
        tick();
        bus.ex_br_taken = 1'b0;
        nop();
        #1;
        n_cmp++; if (vld() !== 3'b011) begin n_err++; $display("FAIL fz_after_valid: got %b want 011", vld()); end
        n_cmp++; if (bus.flush_cnt !== 4'd2) begin n_err++; $display("FAIL fz_flush_cnt: got %0d want 2", bus.flush_cnt); end
        drain();
    endtask

    task automatic test_x0();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, WB_ALU);   // addi x0,x0,5
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, WB_ALU);   // add x1,x0,x0
        #1;
        n_cmp++; if (ctl() !== CTL_RUN) begin n_err++; $display("FAIL x0_nostall: got %b want %b", ctl(), CTL_RUN); end
        tick();
        nop();
        #1;
        n_cmp++; if ({bus.ex_fwd_rs1, bus.ex_fwd_rs2} !== 4'b0000) begin n_err++; $display("FAIL x0_fwd: got %b want 0000", {bus.ex_fwd_rs1, bus.ex_fwd_rs2}); end
        drain();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, WB_MEM);   // lw x0
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, WB_ALU);
        #1;
        n_cmp++; if (ctl() !== CTL_RUN) begin n_err++; $display("FAIL x0_load_nostall: got %b want %b", ctl(), CTL_RUN); end
        drain();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, WB_MEM);   // lw x5
        tick();
        drive(1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, WB_ALU);   // invalid consumer
        #1;
        n_cmp++; if (ctl() !== CTL_RUN) begin n_err++; $display("FAIL idv0_nostall: got %b want %b", ctl(), CTL_RUN); end
        drain();
        n_cmp++; if (bus.stall_cnt !== 4'd1) begin n_err++; $display("FAIL x0_stall_cnt: got %0d want 1", bus.stall_cnt); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, WB_MEM);
            tick();
            drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, WB_ALU);
            tick();
            nop();
            tick();
            if (i == 12) begin
                n_cmp++; if (bus.stall_cnt !== 4'd14) begin n_err++; $display("FAIL sat_mid: got %0d want 14", bus.stall_cnt); end
            end
        end
        n_cmp++; if (bus.stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_hold: got %0d want 15", bus.stall_cnt); end
        drain();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, WB_MEM);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, WB_ALU);
        #1;
        n_cmp++; if (ctl() !== CTL_STALL) begin n_err++; $display("FAIL rm_stall: got %b want %b", ctl(), CTL_STALL); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.stall_cnt, bus.flush_cnt} !== 8'd0) begin n_err++; $display("FAIL rm_cnt: got %h want 00", {bus.stall_cnt, bus.flush_cnt}); end
        n_cmp++; if (vld() !== 3'b000) begin n_err++; $display("FAIL rm_valid: got %b want 000", vld()); end
        n_cmp++; if (ctl() !== CTL_RUN) begin n_err++; $display("FAIL rm_ctl: got %b want %b", ctl(), CTL_RUN); end
        nop();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_load_use();
        test_forward();
        test_flush();
        test_freeze();
        test_x0();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
